// File: rtl/float_result_reorder_buffer_pkg.sv
// Shared types for the floating-point result reorder buffer.
// FLEN is the operand width of the floating-point subsystem.
package float_result_reorder_buffer_pkg;

    localparam int FLEN = 64;

    typedef struct packed {
        logic [FLEN-1:0] res;
        logic            neg;
        logic            err;
    } float_entry_t;

endpackage

// File: rtl/float_result_reorder_buffer_if.sv
// Allocation, return and in-order result signals of the reorder buffer.
// The master side is issue logic plus workers; the slave side is the buffer.
interface float_result_reorder_buffer_if
    import float_result_reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    localparam int TW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alloc_req;
    logic [TW-1:0]   alloc_tag;
    logic            busy;
    logic [CW-1:0]   count;
    logic            ret_vld;
    logic [TW-1:0]   ret_tag;
    logic [FLEN-1:0] ret_res;
    logic            ret_neg;
    logic            ret_err;
    logic            res_vld;
    logic [FLEN-1:0] res;
    logic            res_negative;
    logic            err;
    logic            prot_err;

    modport master (
        output alloc_req, ret_vld, ret_tag, ret_res, ret_neg, ret_err,
        input  alloc_tag, busy, count, res_vld, res, res_negative, err, prot_err
    );

    modport slave (
        input  alloc_req, ret_vld, ret_tag, ret_res, ret_neg, ret_err,
        output alloc_tag, busy, count, res_vld, res, res_negative, err, prot_err
    );

endinterface

// File: rtl/float_result_reorder_buffer_ring_ptr.sv
// Modulo-DEPTH pointer used for the head and tail of the reorder buffer.
// It advances by one on inc and wraps from DEPTH-1 back to 0.
module ring_ptr #(
    parameter  int DEPTH = 8,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [TW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == TW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/float_result_reorder_buffer.sv
// In-order retirement buffer: tags are allocated in program order, results
// return in any order and leave one per cycle in allocation order.
module float_result_reorder_buffer
    import float_result_reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                          clk,
    input logic                          rst,
    float_result_reorder_buffer_if.slave bus
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] done_q;
    float_entry_t     entry_q [DEPTH];
    logic [TW-1:0]    head;
    logic [TW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             alloc_ok;
    logic             ret_ok;
    logic             retire;

    assign full     = (count_q == CW'(DEPTH));
    assign alloc_ok = bus.alloc_req && !full;
    assign ret_ok   = bus.ret_vld && alloc_q[bus.ret_tag] && !done_q[bus.ret_tag];
    // Retire looks only at registered done bits, so a return to the head
    // entry is written on one edge and retired on the next.
    assign retire   = alloc_q[head] && done_q[head];

    assign bus.alloc_tag = tail;
    assign bus.busy      = full;
    assign bus.count     = count_q;

    ring_ptr #(.DEPTH(DEPTH)) head_ptr (
        .clk (clk),
        .rst (rst),
        .inc (retire),
        .ptr (head)
    );

    ring_ptr #(.DEPTH(DEPTH)) tail_ptr (
        .clk (clk),
        .rst (rst),
        .inc (alloc_ok),
        .ptr (tail)
    );

    // Retire, allocate and return always hit distinct entries, so their
    // bit updates never collide within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            if (retire) begin
                alloc_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
            end
            if (alloc_ok) begin
                alloc_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
            end
            if (ret_ok) begin
                done_q[bus.ret_tag] <= 1'b1;
            end
            count_q <= count_q + CW'(alloc_ok) - CW'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (ret_ok) begin
            entry_q[bus.ret_tag] <= '{res: bus.ret_res, neg: bus.ret_neg, err: bus.ret_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_vld      <= 1'b0;
            bus.res          <= '0;
            bus.res_negative <= 1'b0;
            bus.err          <= 1'b0;
            bus.prot_err     <= 1'b0;
        end else begin
            bus.res_vld  <= retire;
            bus.prot_err <= bus.ret_vld && !ret_ok;
            if (retire) begin
                bus.res          <= entry_q[head].res;
                bus.res_negative <= entry_q[head].neg;
                bus.err          <= entry_q[head].err;
            end
        end
    end

endmodule

// File: tb/tb_float_result_reorder_buffer.sv
// Directed bench for float_result_reorder_buffer (DEPTH=8, FLEN=64) with
// hand-computed expected values checked by immediate assertions.
module tb_float_result_reorder_buffer;
    import float_result_reorder_buffer_pkg::*;

    localparam int DEPTH = 8;

    localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F4  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F5  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] FM2 = 64'hC000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    float_result_reorder_buffer_if #(.DEPTH(DEPTH)) bus ();

    float_result_reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic apply_stimulus(input logic a_req, input logic r_vld, input logic [2:0] r_tag,
                                  input logic [63:0] r_res, input logic r_neg, input logic r_err);
        bus.alloc_req = a_req;
        bus.ret_vld   = r_vld;
        bus.ret_tag   = r_tag;
        bus.ret_res   = r_res;
        bus.ret_neg   = r_neg;
        bus.ret_err   = r_err;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset state");
        check_output("rst_res_vld", 64'(bus.res_vld), 64'd0);
        check_output("rst_res", bus.res, 64'd0);
        check_output("rst_neg", 64'(bus.res_negative), 64'd0);
        check_output("rst_err", 64'(bus.err), 64'd0);
        check_output("rst_prot", 64'(bus.prot_err), 64'd0);
        check_output("rst_count", 64'(bus.count), 64'd0);
        check_output("rst_busy", 64'(bus.busy), 64'd0);
        check_output("rst_tag", 64'(bus.alloc_tag), 64'd0);

        $display("[TB] in-order returns");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
            #1;
            check_output("io_alloc_tag", 64'(bus.alloc_tag), 64'(i));
            tick();
        end
        idle();
        check_output("io_count3", 64'(bus.count), 64'd3);
        apply_stimulus(1'b0, 1'b1, 3'd0, F1, 1'b0, 1'b0);
        tick();
        check_output("io_no_vld", 64'(bus.res_vld), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd1, F2, 1'b0, 1'b0);
        tick();
        check_output("io_vld0", 64'(bus.res_vld), 64'd1);
        check_output("io_res0", bus.res, F1);
        apply_stimulus(1'b0, 1'b1, 3'd2, F3, 1'b0, 1'b0);
        tick();
        check_output("io_vld1", 64'(bus.res_vld), 64'd1);
        check_output("io_res1", bus.res, F2);
        idle();
        tick();
        check_output("io_vld2", 64'(bus.res_vld), 64'd1);
        check_output("io_res2", bus.res, F3);
        check_output("io_count0", 64'(bus.count), 64'd0);
        tick();
        check_output("io_vld_low", 64'(bus.res_vld), 64'd0);
        check_output("io_res_hold", bus.res, F3);

        $display("[TB] reverse-order returns");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
            #1;
            check_output("rv_alloc_tag", 64'(bus.alloc_tag), 64'(3 + i));
            tick();
        end
        apply_stimulus(1'b0, 1'b1, 3'd6, F4, 1'b0, 1'b0);
        tick();
        check_output("rv_hold6", 64'(bus.res_vld), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd5, F3, 1'b0, 1'b0);
        tick();
        check_output("rv_hold5", 64'(bus.res_vld), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd4, F2, 1'b0, 1'b0);
        tick();
        check_output("rv_hold4", 64'(bus.res_vld), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd3, F1, 1'b0, 1'b0);
        tick();
        check_output("rv_hold3", 64'(bus.res_vld), 64'd0);
        idle();
        tick();
        check_output("rv_vld_a", 64'(bus.res_vld), 64'd1);
        check_output("rv_res_a", bus.res, F1);
        tick();
        check_output("rv_vld_b", 64'(bus.res_vld), 64'd1);
        check_output("rv_res_b", bus.res, F2);
        tick();
        check_output("rv_vld_c", 64'(bus.res_vld), 64'd1);
        check_output("rv_res_c", bus.res, F3);
        tick();
        check_output("rv_vld_d", 64'(bus.res_vld), 64'd1);
        check_output("rv_res_d", bus.res, F4);
        tick();
        check_output("rv_done", 64'(bus.res_vld), 64'd0);
        check_output("rv_count", 64'(bus.count), 64'd0);

        $display("[TB] full buffer");
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
            tick();
        end
        check_output("full_busy", 64'(bus.busy), 64'd1);
        check_output("full_count", 64'(bus.count), 64'd8);
        check_output("full_tag", 64'(bus.alloc_tag), 64'd0);
        tick();
        check_output("full_ignored_count", 64'(bus.count), 64'd8);
        check_output("full_ignored_tag", 64'(bus.alloc_tag), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd0, F5, 1'b0, 1'b0);
        tick();
        check_output("full_ret_busy", 64'(bus.busy), 64'd1);
        apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
        tick();
        check_output("full_ret_vld", 64'(bus.res_vld), 64'd1);
        check_output("full_ret_res", bus.res, F5);
        check_output("full_rej_count", 64'(bus.count), 64'd7);
        check_output("full_busy_drop", 64'(bus.busy), 64'd0);
        check_output("full_rej_tag", 64'(bus.alloc_tag), 64'd0);
        tick();
        check_output("wrap_count", 64'(bus.count), 64'd8);
        check_output("wrap_busy", 64'(bus.busy), 64'd1);
        check_output("wrap_tag", 64'(bus.alloc_tag), 64'd1);

        $display("[TB] protocol errors");
        do_reset();
        apply_stimulus(1'b0, 1'b1, 3'd5, F1, 1'b0, 1'b0);
        tick();
        check_output("pe_unalloc", 64'(bus.prot_err), 64'd1);
        check_output("pe_count", 64'(bus.count), 64'd0);
        check_output("pe_no_vld", 64'(bus.res_vld), 64'd0);
        idle();
        tick();
        check_output("pe_pulse", 64'(bus.prot_err), 64'd0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd0, F2, 1'b0, 1'b0);
        tick();
        check_output("pe_first_ok", 64'(bus.prot_err), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd0, F4, 1'b0, 1'b0);
        tick();
        check_output("pe_dup", 64'(bus.prot_err), 64'd1);
        check_output("pe_dup_vld", 64'(bus.res_vld), 64'd1);
        check_output("pe_dup_res", bus.res, F2);
        idle();
        tick();
        check_output("pe_clear", 64'(bus.prot_err), 64'd0);

        $display("[TB] flags");
        apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
        #1;
        check_output("fl_tag", 64'(bus.alloc_tag), 64'd1);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd1, FM2, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd2, F1, 1'b0, 1'b0);
        tick();
        check_output("fl_vld_a", 64'(bus.res_vld), 64'd1);
        check_output("fl_res_a", bus.res, FM2);
        check_output("fl_neg_a", 64'(bus.res_negative), 64'd1);
        check_output("fl_err_a", 64'(bus.err), 64'd1);
        idle();
        tick();
        check_output("fl_res_b", bus.res, F1);
        check_output("fl_neg_b", 64'(bus.res_negative), 64'd0);
        check_output("fl_err_b", 64'(bus.err), 64'd0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 1'b1, 3'd4, F3, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b1, 3'd5, F4, 1'b0, 1'b0);
        tick();
        check_output("mr_count4", 64'(bus.count), 64'd4);
        do_reset();
        check_output("mr_count0", 64'(bus.count), 64'd0);
        check_output("mr_no_vld", 64'(bus.res_vld), 64'd0);
        check_output("mr_tag", 64'(bus.alloc_tag), 64'd0);
        check_output("mr_busy", 64'(bus.busy), 64'd0);
        tick();
        check_output("mr_still_no_vld", 64'(bus.res_vld), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd1, F1, 1'b0, 1'b0);
        tick();
        check_output("mr_stale", 64'(bus.prot_err), 64'd1);
        check_output("mr_stale_vld", 64'(bus.res_vld), 64'd0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/float_result_reorder_buffer.md
# float_result_reorder_buffer

In-order retirement buffer for the floating-point arithmetic subsystem. Issue logic allocates a tag per operation in program order. Worker units return results tagged and in any order. The block emits results strictly in allocation order, one per cycle, so downstream sees a single in-order result stream.

## Interface

- DEPTH, 8: number of tags / entries, ≥2; tag width TW = $clog2(DEPTH)
- FLEN, from shared package: floating-point operand width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  1  request a tag for a new operation
- alloc_tag  out  TW  tag granted to alloc_req this cycle; combinational, equals tail pointer
- busy  out  1  all DEPTH entries allocated; alloc_req ignored while high
- count  out  $clog2(DEPTH+1)  number of allocated entries (registered)
- ret_vld  in  1  worker result valid
- ret_tag  in  TW  tag of returned result
- ret_res  in  FLEN  result value
- ret_neg  in  1  result-negative flag
- ret_err  in  1  result error flag
- res_vld  out  1  in-order result valid, one-cycle pulse per entry
- res  out  FLEN  in-order result
- res_negative  out  1  flag of emitted entry
- err  out  1  error flag of emitted entry
- prot_err  out  1  one-cycle pulse: ret_vld on an unallocated or already-done tag; that return is dropped

## Operation

- Per entry: alloc bit, done bit, payload {res, neg, err}. Head pointer (oldest) and tail pointer (next free), both wrap DEPTH-1 → 0.
- Allocate: alloc_req && !busy at an edge sets alloc[tail], clears done[tail], tail++. Tag = alloc_tag presented that cycle.
- Return: ret_vld && alloc[ret_tag] && !done[ret_tag] writes payload, sets done. Any other ret_vld: no state change, prot_err pulses next cycle.
- Retire: when alloc[head] && done[head], register payload onto outputs, pulse res_vld, clear alloc/done[head], head++. At most one retire per cycle.
- count next = count + alloc_accepted − retire. busy = (count == DEPTH).
- Full: alloc rejected even if a retire happens in the same cycle; busy drops the cycle after the retire.
- Empty: no res_vld; alloc_tag = head.
- Simultaneous alloc, return, and retire on distinct entries: all take effect in the same edge.
- Return to the head entry while the head is not done: written this edge; retired the next edge.
- res, res_negative, and err hold their last value when res_vld is low.

## Timing

- Reset values: res_vld 0, res 0, res_negative 0, err 0, prot_err 0, count 0, busy 0, alloc_tag 0. All alloc and done bits clear, head = tail = 0.
- Reset mid-operation: all pending entries are discarded without output. Returns arriving after reset for old tags produce prot_err.
- Allocation latency: tag valid in the request cycle; entry counted from the next cycle.
- Return → result: ret_vld sampled at edge E (entry is head) → res_vld high in the cycle after edge E+1 (2-cycle latency).
- Throughput: one alloc and one retire per cycle sustained. A full buffer whose head is done retires every cycle.
- prot_err is asserted in the cycle after the offending return.

## Structure

- Shared package holds FLEN and typedef float_entry_t {logic [FLEN-1:0] res; logic neg; logic err;}.
- Pointer wrap uses a small sub-module ring_ptr (parameter DEPTH; inputs inc, rst; output ptr), instantiated twice for head and tail.
- Payload storage is a flop array of float_entry_t. There is no RAM macro, because of the same-cycle write/read of distinct entries.

## Test plan

- In-order: with FLEN=64, allocate tags 0,1,2; return 1.0 (3FF0…0), 2.0 (4000…0), 3.0 (4008…0) in tag order → res_vld pulses in 3 consecutive cycles with 1.0, 2.0, 3.0, each 2 cycles after its return.
- Reverse: allocate 0..3, return tags 3,2,1,0 with values 4,3,2,1 → no res_vld until tag 0 returns, then 1,2,3,4 on four back-to-back cycles.
- Full: DEPTH=8, allocate 8 → busy=1, count=8, 9th alloc_req ignored (tail unchanged). Return tag 0 → retire, busy=0 next cycle, next alloc gets tag 0 (wrap).
- Protocol error: return tag 5 when unallocated → prot_err pulse, count unchanged, no res_vld. Return tag 0 twice → second return flags prot_err, first value kept.
- Flags: return with ret_neg=1, ret_err=1 → emitted with res_negative=1, err=1. The following entry with flags 0 shows 0.
- Reset: 4 allocated, 2 done, assert rst 1 cycle → count=0, no res_vld. A stale return of tag 1 → prot_err.
